// File: rtl/sdram_rd_pkg.sv
// Shared types and constants for the SDRAM read prefetcher.
package sdram_rd_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2
    } state_e;

    localparam int unsigned NumBanks = 2;

    // Byte-to-word address shift for a given data width.
    function automatic int unsigned addr_shift(input int unsigned dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/dual_port_ram.sv
// Simple dual-port buffer: synchronous write on wclk_i, registered read on rclk_i.
module dual_port_ram #(
    parameter int unsigned DATAWIDTH = 16,
    parameter int unsigned ASIZE     = 4
) (
    input  logic                 wclk_i,
    input  logic                 we_i,
    input  logic [ASIZE-1:0]     waddr_i,
    input  logic [DATAWIDTH-1:0] wdata_i,
    input  logic                 rclk_i,
    input  logic                 rst_ni,
    input  logic                 re_i,
    input  logic [ASIZE-1:0]     raddr_i,
    output logic [DATAWIDTH-1:0] rdata_o
);

    localparam int unsigned Depth = 1 << ASIZE;

    logic [DATAWIDTH-1:0] mem_q [Depth];
    logic [DATAWIDTH-1:0] rdata_q;

    always_ff @(posedge wclk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge rclk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_rd_prefetch.sv
// Demand-driven SDRAM burst reader into a two-bank buffer read from the QSPI side.
// Optional next-burst prefetch is enabled with SDRAM_RD_PREFETCH_EN.
module sdram_rd_prefetch
    import sdram_rd_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 24,
    parameter int unsigned BL = 8
) (
    input  logic                  sdram_clk,
    input  logic                  rst_n,
    input  logic                  qspi_clk,
    input  logic                  qspi_rd_req,
    input  logic [AW-1:0]         qspi_rd_addr,
    input  logic                  ram_ren,
    input  logic [$clog2(BL):0]   ram_raddr,
    output logic [DW-1:0]         ram_rdata,
    output logic [AW-1:0]         rd_addr,
    output logic                  rd_avalid,
    input  logic                  rd_aready,
    input  logic [DW-1:0]         rd_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    output logic [NumBanks-1:0]   buf_vld,
    output logic                  demand_bank
);

    localparam int unsigned CW    = $clog2(BL);
    localparam int unsigned Shift = addr_shift(DW);
`ifdef SDRAM_RD_PREFETCH_EN
    localparam bit PfEn = 1'b1;
`else
    localparam bit PfEn = 1'b0;
`endif

    state_e               state_q, state_d;
    logic                 sync0_q, sync1_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        rd_addr_q, rd_addr_d;
    logic                 bank_q, bank_d;
    logic                 is_pf_q, is_pf_d;
    logic [NumBanks-1:0]  buf_vld_q, buf_vld_d;
    logic                 demand_bank_q, demand_bank_d;
    logic                 next_bank_q, next_bank_d;
    logic                 pend_dmd_q, pend_dmd_d;
    logic [AW-1:0]        pend_addr_q, pend_addr_d;
    logic                 pend_pf_q, pend_pf_d;
    logic [AW-1:0]        pf_addr_q, pf_addr_d;
    logic                 pf_done_q, pf_done_d;

    logic                 demand_evt;
    logic [AW-1:0]        req_waddr;
    logic [AW-1:0]        dmd_addr;
    logic                 pf_hit;

    assign demand_evt = sync0_q & ~sync1_q;
    assign req_waddr  = qspi_rd_addr >> Shift;
    assign dmd_addr   = demand_evt ? req_waddr : pend_addr_q;

`ifdef SDRAM_RD_PREFETCH_EN
    assign pf_hit = pf_done_q & buf_vld_q[~demand_bank_q] & (dmd_addr == pf_addr_q);
`else
    assign pf_hit = 1'b0;
`endif

    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            sync0_q       <= 1'b0;
            sync1_q       <= 1'b0;
            cnt_q         <= '0;
            rd_addr_q     <= '0;
            bank_q        <= 1'b0;
            is_pf_q       <= 1'b0;
            buf_vld_q     <= '0;
            demand_bank_q <= 1'b0;
            next_bank_q   <= 1'b0;
            pend_dmd_q    <= 1'b0;
            pend_addr_q   <= '0;
            pend_pf_q     <= 1'b0;
            pf_addr_q     <= '0;
            pf_done_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync0_q       <= qspi_rd_req;
            sync1_q       <= sync0_q;
            cnt_q         <= cnt_d;
            rd_addr_q     <= rd_addr_d;
            bank_q        <= bank_d;
            is_pf_q       <= is_pf_d;
            buf_vld_q     <= buf_vld_d;
            demand_bank_q <= demand_bank_d;
            next_bank_q   <= next_bank_d;
            pend_dmd_q    <= pend_dmd_d;
            pend_addr_q   <= pend_addr_d;
            pend_pf_q     <= pend_pf_d;
            pf_addr_q     <= pf_addr_d;
            pf_done_q     <= pf_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_addr_d     = rd_addr_q;
        bank_d        = bank_q;
        is_pf_d       = is_pf_q;
        buf_vld_d     = buf_vld_q;
        demand_bank_d = demand_bank_q;
        next_bank_d   = next_bank_q;
        pend_dmd_d    = pend_dmd_q;
        pend_addr_d   = pend_addr_q;
        pend_pf_d     = pend_pf_q;
        pf_addr_d     = pf_addr_q;
        pf_done_d     = pf_done_q;

        case (state_q)
            StIdle: begin
                if (demand_evt || pend_dmd_q) begin
                    pend_dmd_d = 1'b0;
                    pf_done_d  = 1'b0;
                    if (pf_hit) begin
                        // Prefetched bank already holds the data: swap banks, no SDRAM access.
                        demand_bank_d = ~demand_bank_q;
                        next_bank_d   = demand_bank_q;
                        pend_pf_d     = 1'b1;
                        pf_addr_d     = dmd_addr + AW'(BL);
                    end else begin
                        state_d             = StAddr;
                        rd_addr_d           = dmd_addr;
                        bank_d              = next_bank_q;
                        is_pf_d             = 1'b0;
                        demand_bank_d       = next_bank_q;
                        next_bank_d         = ~next_bank_q;
                        buf_vld_d[next_bank_q] = 1'b0;
                        pend_pf_d           = 1'b0;
                        cnt_d               = '0;
                    end
                end else if (pend_pf_q) begin
                    state_d                  = StAddr;
                    rd_addr_d                = pf_addr_q;
                    bank_d                   = ~demand_bank_q;
                    is_pf_d                  = 1'b1;
                    buf_vld_d[~demand_bank_q] = 1'b0;
                    pend_pf_d                = 1'b0;
                    cnt_d                    = '0;
                end
            end
            StAddr: begin
                if (rd_aready) begin
                    state_d = StData;
                end
                if (demand_evt) begin
                    if (PfEn && is_pf_q && !rd_aready) begin
                        // Prefetch not yet accepted: reuse the slot for the demand.
                        rd_addr_d     = req_waddr;
                        is_pf_d       = 1'b0;
                        demand_bank_d = bank_q;
                        next_bank_d   = ~bank_q;
                    end else begin
                        pend_dmd_d  = 1'b1;
                        pend_addr_d = req_waddr;
                    end
                end
            end
            StData: begin
                if (demand_evt) begin
                    pend_dmd_d  = 1'b1;
                    pend_addr_d = req_waddr;
                end
                if (rd_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(BL - 1)) begin
                        state_d           = StIdle;
                        cnt_d             = '0;
                        buf_vld_d[bank_q] = 1'b1;
                        if (is_pf_q) begin
                            pf_done_d = 1'b1;
                        end else if (PfEn) begin
                            pend_pf_d = 1'b1;
                            pf_addr_d = rd_addr_q + AW'(BL);
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rd_avalid   = (state_q == StAddr);
    assign rd_ready    = (state_q == StData);
    assign rd_addr     = rd_addr_q;
    assign buf_vld     = buf_vld_q;
    assign demand_bank = demand_bank_q;

    dual_port_ram #(
        .DATAWIDTH (DW),
        .ASIZE     (CW + 1)
    ) u_buf (
        .wclk_i  (sdram_clk),
        .we_i    (rd_ready & rd_valid),
        .waddr_i ({bank_q, cnt_q}),
        .wdata_i (rd_data),
        .rclk_i  (qspi_clk),
        .rst_ni  (rst_n),
        .re_i    (ram_ren),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_sdram_rd_prefetch.sv
// Directed bench for sdram_rd_prefetch (DW=16, AW=24, BL=8); prefetch scenarios
// run only when SDRAM_RD_PREFETCH_EN is defined.
module tb_sdram_rd_prefetch;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 24;
    localparam int unsigned BL = 8;

    logic          sdram_clk = 1'b0;
    logic          qspi_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          qspi_rd_req = 1'b0;
    logic [AW-1:0] qspi_rd_addr = '0;
    logic          ram_ren = 1'b0;
    logic [3:0]    ram_raddr = '0;
    logic [DW-1:0] ram_rdata;
    logic [AW-1:0] rd_addr;
    logic          rd_avalid;
    logic          rd_aready = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          rd_valid = 1'b0;
    logic          rd_ready;
    logic [1:0]    buf_vld;
    logic          demand_bank;

    int vectors = 0;
    int miscompares = 0;

    always #5 sdram_clk = ~sdram_clk;
    always #7 qspi_clk = ~qspi_clk;

    sdram_rd_prefetch #(
        .DW (DW),
        .AW (AW),
        .BL (BL)
    ) dut (
        .sdram_clk    (sdram_clk),
        .rst_n        (rst_n),
        .qspi_clk     (qspi_clk),
        .qspi_rd_req  (qspi_rd_req),
        .qspi_rd_addr (qspi_rd_addr),
        .ram_ren      (ram_ren),
        .ram_raddr    (ram_raddr),
        .ram_rdata    (ram_rdata),
        .rd_addr      (rd_addr),
        .rd_avalid    (rd_avalid),
        .rd_aready    (rd_aready),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .buf_vld      (buf_vld),
        .demand_bank  (demand_bank)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        qspi_rd_req = 1'b0;
        qspi_rd_addr = '0;
        ram_ren = 1'b0;
        ram_raddr = '0;
        rd_aready = 1'b0;
        rd_valid = 1'b0;
        rd_data = '0;
        repeat (3) @(negedge sdram_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge sdram_clk);
    endtask

    task automatic wait_avalid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge sdram_clk);
            if (rd_avalid) seen = 1'b1;
        end
    endtask

    task automatic addr_hs();
        rd_aready = 1'b1;
        @(negedge sdram_clk);
        rd_aready = 1'b0;
    endtask

    task automatic send_beats(input int n, input int stall_at, input int stall_len,
                              input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                rd_valid = 1'b0;
                rd_data = 16'hDEAD;
                repeat (stall_len) @(negedge sdram_clk);
            end
            rd_valid = 1'b1;
            rd_data = base + 16'(i);
            @(negedge sdram_clk);
        end
        rd_valid = 1'b0;
        rd_data = '0;
    endtask

    task automatic read_word(input logic [3:0] addr, output logic [DW-1:0] data);
        @(negedge qspi_clk);
        ram_ren = 1'b1;
        ram_raddr = addr;
        @(negedge qspi_clk);
        ram_ren = 1'b0;
        data = ram_rdata;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge sdram_clk);
        vectors++;
        if (rd_addr !== 24'h0 || rd_avalid !== 1'b0 || rd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_sdram_if: got addr=%h avalid=%b ready=%b, expected 0/0/0",
                     rd_addr, rd_avalid, rd_ready);
        end
        vectors++;
        if (buf_vld !== 2'b00 || demand_bank !== 1'b0 || ram_rdata !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_status: got vld=%b bank=%b rdata=%h, expected 00/0/0000",
                     buf_vld, demand_bank, ram_rdata);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge sdram_clk);
        vectors++;
        if (rd_avalid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got rd_avalid=%b, expected 0", rd_avalid);
        end
    endtask

    task automatic test_demand();
        bit seen;
        logic [DW-1:0] d;
        do_reset();
        qspi_rd_addr = 24'h000100;
        qspi_rd_req = 1'b1;
        wait_avalid(20, seen);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL demand_avalid: got no rd_avalid in 20 cycles, expected it");
        end
        vectors++;
        if (rd_addr !== 24'h000080 || rd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL demand_addr: got addr=%h ready=%b, expected 000080/0", rd_addr, rd_ready);
        end
        addr_hs();
        vectors++;
        if (rd_ready !== 1'b1 || rd_avalid !== 1'b0) begin
            miscompares++;
            $display("FAIL demand_data_phase: got ready=%b avalid=%b, expected 1/0",
                     rd_ready, rd_avalid);
        end
        send_beats(8, 99, 0, 16'hA000);
        vectors++;
        if (rd_ready !== 1'b0 || buf_vld !== 2'b01 || demand_bank !== 1'b0) begin
            miscompares++;
            $display("FAIL demand_done: got ready=%b vld=%b bank=%b, expected 0/01/0",
                     rd_ready, buf_vld, demand_bank);
        end
        qspi_rd_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            read_word(4'(i), d);
            vectors++;
            if (d !== 16'hA000 + 16'(i)) begin
                miscompares++;
                $display("FAIL demand_buf[%0d]: got %h, expected %h", i, d, 16'hA000 + 16'(i));
            end
        end
    endtask

    task automatic test_stall();
        bit seen;
        logic [DW-1:0] d;
        do_reset();
        qspi_rd_addr = 24'h000040;
        qspi_rd_req = 1'b1;
        wait_avalid(20, seen);
        vectors++;
        if (!seen || rd_addr !== 24'h000020) begin
            miscompares++;
            $display("FAIL stall_addr: got seen=%b addr=%h, expected 1/000020", seen, rd_addr);
        end
        addr_hs();
        send_beats(7, 3, 5, 16'hB000);
        vectors++;
        if (rd_ready !== 1'b1 || buf_vld !== 2'b00) begin
            miscompares++;
            $display("FAIL stall_seven_beats: got ready=%b vld=%b, expected 1/00", rd_ready, buf_vld);
        end
        send_beats(1, 99, 0, 16'hB007);
        vectors++;
        if (rd_ready !== 1'b0 || buf_vld !== 2'b01) begin
            miscompares++;
            $display("FAIL stall_end: got ready=%b vld=%b, expected 0/01", rd_ready, buf_vld);
        end
        qspi_rd_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            read_word(4'(i), d);
            vectors++;
            if (d !== 16'hB000 + 16'(i)) begin
                miscompares++;
                $display("FAIL stall_buf[%0d]: got %h, expected %h", i, d, 16'hB000 + 16'(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        int extra;
        do_reset();
        qspi_rd_addr = 24'h000200;
        qspi_rd_req = 1'b1;
        wait_avalid(20, seen);
        addr_hs();
        send_beats(3, 99, 0, 16'h1000);
        qspi_rd_req = 1'b0;
        send_beats(2, 99, 0, 16'h1003);
        qspi_rd_addr = 24'h000300;
        qspi_rd_req = 1'b1;
        send_beats(3, 99, 0, 16'h1005);
        vectors++;
        if (buf_vld !== 2'b01 || rd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first_done: got vld=%b ready=%b, expected 01/0", buf_vld, rd_ready);
        end
        wait_avalid(6, seen);
        vectors++;
        if (!seen || rd_addr !== 24'h000180 || demand_bank !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second_addr: got seen=%b addr=%h bank=%b, expected 1/000180/1",
                     seen, rd_addr, demand_bank);
        end
        addr_hs();
        send_beats(8, 99, 0, 16'h2000);
        qspi_rd_req = 1'b0;
        vectors++;
        if (buf_vld !== 2'b11) begin
            miscompares++;
            $display("FAIL b2b_second_done: got vld=%b, expected 11", buf_vld);
        end
`ifndef SDRAM_RD_PREFETCH_EN
        extra = 0;
        repeat (20) begin
            @(negedge sdram_clk);
            if (rd_avalid) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL b2b_no_third: got %0d avalid cycles, expected 0", extra);
        end
`endif
    endtask

    task automatic test_collapse();
        bit seen;
        int extra;
        do_reset();
        qspi_rd_addr = 24'h000000;
        qspi_rd_req = 1'b1;
        wait_avalid(20, seen);
        addr_hs();
        qspi_rd_req = 1'b0;
        repeat (3) @(negedge sdram_clk);
        qspi_rd_addr = 24'h000040;
        qspi_rd_req = 1'b1;
        repeat (3) @(negedge sdram_clk);
        qspi_rd_req = 1'b0;
        repeat (3) @(negedge sdram_clk);
        qspi_rd_addr = 24'h000060;
        qspi_rd_req = 1'b1;
        repeat (3) @(negedge sdram_clk);
        send_beats(8, 99, 0, 16'h3000);
        wait_avalid(6, seen);
        vectors++;
        if (!seen || rd_addr !== 24'h000030 || demand_bank !== 1'b1) begin
            miscompares++;
            $display("FAIL collapse_addr: got seen=%b addr=%h bank=%b, expected 1/000030/1",
                     seen, rd_addr, demand_bank);
        end
        addr_hs();
        send_beats(8, 99, 0, 16'h4000);
        qspi_rd_req = 1'b0;
`ifndef SDRAM_RD_PREFETCH_EN
        extra = 0;
        repeat (20) begin
            @(negedge sdram_clk);
            if (rd_avalid) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL collapse_single: got %0d avalid cycles, expected 0", extra);
        end
`endif
    endtask

    task automatic test_reset_mid();
        bit seen;
        int rdy;
        logic [DW-1:0] d;
        do_reset();
        qspi_rd_addr = 24'h000100;
        qspi_rd_req = 1'b1;
        wait_avalid(20, seen);
        addr_hs();
        send_beats(4, 99, 0, 16'hC000);
        read_word(4'h0, d);
        vectors++;
        if (d !== 16'hC000) begin
            miscompares++;
            $display("FAIL rstmid_pre_read: got %h, expected c000", d);
        end
        @(negedge sdram_clk);
        rd_valid = 1'b1;
        rd_data = 16'hC004;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rd_ready !== 1'b0 || rd_avalid !== 1'b0 || rd_addr !== 24'h0 || buf_vld !== 2'b00 ||
            demand_bank !== 1'b0 || ram_rdata !== 16'h0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got rdy=%b av=%b addr=%h vld=%b bank=%b rdata=%h, expected all 0",
                     rd_ready, rd_avalid, rd_addr, buf_vld, demand_bank, ram_rdata);
        end
        qspi_rd_req = 1'b0;
        repeat (2) @(negedge sdram_clk);
        rst_n = 1'b1;
        rdy = 0;
        repeat (10) begin
            @(negedge sdram_clk);
            if (rd_ready) rdy++;
        end
        rd_valid = 1'b0;
        vectors++;
        if (rdy !== 0 || buf_vld !== 2'b00) begin
            miscompares++;
            $display("FAIL rstmid_abandon: got ready_cycles=%0d vld=%b, expected 0/00", rdy, buf_vld);
        end
    endtask

`ifdef SDRAM_RD_PREFETCH_EN
    task automatic test_prefetch();
        bit seen;
        bit bad;
        do_reset();
        qspi_rd_addr = 24'h000100;
        qspi_rd_req = 1'b1;
        wait_avalid(20, seen);
        addr_hs();
        send_beats(8, 99, 0, 16'hD000);
        wait_avalid(6, seen);
        vectors++;
        if (!seen || rd_addr !== 24'h000088) begin
            miscompares++;
            $display("FAIL pf_addr: got seen=%b addr=%h, expected 1/000088", seen, rd_addr);
        end
        addr_hs();
        send_beats(8, 99, 0, 16'hE000);
        vectors++;
        if (buf_vld !== 2'b11 || demand_bank !== 1'b0) begin
            miscompares++;
            $display("FAIL pf_done: got vld=%b bank=%b, expected 11/0", buf_vld, demand_bank);
        end
        qspi_rd_req = 1'b0;
        repeat (3) @(negedge sdram_clk);
        qspi_rd_addr = 24'h000110;
        qspi_rd_req = 1'b1;
        seen = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge sdram_clk);
            if (rd_avalid) bad = 1'b1;
            if (demand_bank) seen = 1'b1;
        end
        vectors++;
        if (!seen || bad) begin
            miscompares++;
            $display("FAIL pf_hit: got bank_switch=%b avalid_seen=%b, expected 1/0", seen, bad);
        end
        wait_avalid(6, seen);
        vectors++;
        if (!seen || rd_addr !== 24'h000090) begin
            miscompares++;
            $display("FAIL pf_next: got seen=%b addr=%h, expected 1/000090", seen, rd_addr);
        end
        addr_hs();
        send_beats(8, 99, 0, 16'hF000);
        qspi_rd_req = 1'b0;

        // Byte 0xFFFFFE is word 0x7FFFFF; +BL lands at 0x800007 within 2^24.
        do_reset();
        qspi_rd_addr = 24'hFFFFFE;
        qspi_rd_req = 1'b1;
        wait_avalid(20, seen);
        vectors++;
        if (!seen || rd_addr !== 24'h7FFFFF) begin
            miscompares++;
            $display("FAIL wrap_demand: got seen=%b addr=%h, expected 1/7fffff", seen, rd_addr);
        end
        addr_hs();
        send_beats(8, 99, 0, 16'h5000);
        wait_avalid(6, seen);
        vectors++;
        if (!seen || rd_addr !== 24'h800007) begin
            miscompares++;
            $display("FAIL wrap_pf: got seen=%b addr=%h, expected 1/800007", seen, rd_addr);
        end
        addr_hs();
        send_beats(8, 99, 0, 16'h6000);
        qspi_rd_req = 1'b0;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_demand();
        test_stall();
        test_back_to_back();
        test_collapse();
        test_reset_mid();
`ifdef SDRAM_RD_PREFETCH_EN
        test_prefetch();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
